// File: rtl/divider_4b.sv
// -----------------------------------------------------------------------------
// divider_4b
// Multi-cycle unsigned restoring divider. A request is taken in IDLE, the
// quotient is built one bit per cycle in CALC (W cycles) by trial subtraction,
// and a single-cycle DONE state presents the result. A zero divisor skips CALC
// and reports quotient = all ones, remainder = dividend, div_by_zero = 1.
//
// Ports
//   clk         : clock, all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   start       : division request, only honoured in IDLE
//   dividend    : W-bit unsigned numerator, captured with start
//   divisor     : W-bit unsigned denominator, captured with start
//   busy        : high exactly while in CALC
//   done        : one-cycle pulse, high exactly while in DONE
//   quotient    : registered quotient, held until the next completion
//   remainder   : registered remainder, held until the next completion
//   div_by_zero : registered divide-by-zero flag, valid with quotient
// -----------------------------------------------------------------------------
module divider_4b #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int            CW       = $clog2(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_r;
    state_t state_s;

    // dvd_r starts as the dividend; each CALC cycle its MSB feeds the partial
    // remainder and the new quotient bit enters at the LSB, so after W shifts
    // it holds the quotient. This keeps partial results off the output ports.
    logic [W-1:0]  dvd_r;
    logic [W-1:0]  dvs_r;
    logic [W-1:0]  rem_r;
    logic [CW-1:0] cnt_r;

    logic [W:0]    shifted_s;
    logic [W:0]    trial_s;
    logic [W-1:0]  rem_next_s;
    logic          qbit_s;
    logic          accept_s;
    logic          zero_s;
    logic          finish_s;

    // One restoring step: shift in the dividend MSB and try to subtract.
    always_comb begin
        shifted_s = {rem_r, dvd_r[W-1]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if (trial_s[W] == 1'b0) begin
            qbit_s     = 1'b1;
            rem_next_s = trial_s[W-1:0];
        end else begin
            qbit_s     = 1'b0;
            rem_next_s = shifted_s[W-1:0];
        end
    end

    // Next-state logic and the per-cycle control strobes.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        zero_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start == 1'b1) begin
                    accept_s = 1'b1;
                    if (divisor == {W{1'b0}}) begin
                        zero_s  = 1'b1;
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == CNT_ZERO) begin
                    finish_s = 1'b1;
                    state_s  = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register; busy/done are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s == CALC);
            done    <= (state_s == DONE);
        end
    end

    // Operand capture and the iterative datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_r <= {W{1'b0}};
            dvs_r <= {W{1'b0}};
            rem_r <= {W{1'b0}};
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            rem_r <= {W{1'b0}};
            cnt_r <= CNT_LAST;
        end else if (state_r == CALC) begin
            dvd_r <= {dvd_r[W-2:0], qbit_s};
            rem_r <= rem_next_s;
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            dvd_r <= dvd_r;
            dvs_r <= dvs_r;
            rem_r <= rem_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers: written only on completion, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= {W{1'b0}};
            remainder   <= {W{1'b0}};
            div_by_zero <= 1'b0;
        end else if (zero_s) begin
            quotient    <= {W{1'b1}};
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (finish_s) begin
            quotient    <= {dvd_r[W-2:0], qbit_s};
            remainder   <= rem_next_s;
            div_by_zero <= 1'b0;
        end else begin
            quotient    <= quotient;
            remainder   <= remainder;
            div_by_zero <= div_by_zero;
        end
    end

endmodule

// File: tb/tb_divider_4b.sv
// -----------------------------------------------------------------------------
// tb_divider_4b
// Self-checking bench for divider_4b (W = 4): a table of fixed vectors, hand
// sequences for start-while-busy and mid-operation reset, random operations
// and a full sweep of all 256 operand pairs, all compared against an
// arithmetic reference model. Outputs are sampled 1 time unit after rising
// edges; inputs change on falling edges.
// -----------------------------------------------------------------------------
module tb_divider_4b;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    divider_4b #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, all-ones quotient on a zero divisor.
    function automatic void ref_div(input int a, input int b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = {W{1'b1}};
            r = W'(a);
            z = 1'b1;
        end else begin
            q = W'(a / b);
            r = W'(a % b);
            z = 1'b0;
        end
    endfunction

    // Called just after the accepting edge. Watches busy and the held result
    // ports until done, then checks latency, results and the one-cycle pulse.
    task automatic finish_op(input logic nz, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic ez, input logic [W-1:0] q0, input logic [W-1:0] r0,
                             input logic z0, input string tag);
        int   k;
        logic prof_ok;
        k       = 0;
        prof_ok = 1'b1;
        while (done !== 1'b1 && k < W + 4) begin
            if (busy !== (nz && k < W)) prof_ok = 1'b0;
            if (quotient !== q0 || remainder !== r0 || div_by_zero !== z0) prof_ok = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check({tag, " busy/hold"}, 32'(prof_ok), 32'd1);
        check({tag, " latency"}, 32'(k), nz ? 32'(W) : 32'd0);
        check({tag, " busy@done"}, 32'(busy), 32'd0);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        @(posedge clk); #1;
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    // One complete operation; operands are scrambled right after the start
    // edge so a design that reads them late gets a wrong answer.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input string tag);
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        logic         z0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        q0 = quotient;
        r0 = remainder;
        z0 = div_by_zero;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        finish_op(b != {W{1'b0}}, eq, er, ez, q0, r0, z0, tag);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t         vecs[$];
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mz;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs.push_back('{4'd13, 4'd4,  4'd3,  4'd1,  1'b0});
        vecs.push_back('{4'd15, 4'd1,  4'd15, 4'd0,  1'b0});
        vecs.push_back('{4'd3,  4'd7,  4'd0,  4'd3,  1'b0});
        vecs.push_back('{4'd0,  4'd5,  4'd0,  4'd0,  1'b0});
        vecs.push_back('{4'd9,  4'd0,  4'd15, 4'd9,  1'b1});
        vecs.push_back('{4'd15, 4'd15, 4'd1,  4'd0,  1'b0});
        vecs.push_back('{4'd1,  4'd15, 4'd0,  4'd1,  1'b0});
        vecs.push_back('{4'd14, 4'd3,  4'd4,  4'd2,  1'b0});
        vecs.push_back('{4'd0,  4'd0,  4'd15, 4'd0,  1'b1});
        vecs.push_back('{4'd8,  4'd2,  4'd4,  4'd0,  1'b0});

        // Reset state
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        #3;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);

        // Release just after a falling edge with start already high: the
        // first rising edge out of reset must accept the request.
        @(negedge clk); @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_op(1'b1, 4'd3, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, "first after reset");

        // Fixed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            do_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
                   $sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b));
        end

        // start held high through CALC and DONE with different operands
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 4'd4;
        start    = 1'b1;
        mq = quotient;
        mr = remainder;
        mz = div_by_zero;
        @(posedge clk); #1;
        dividend = 4'd15;
        divisor  = 4'd1;
        finish_op(1'b1, 4'd3, 4'd1, 1'b0, mq, mr, mz, "held start first");
        check("held start idle gap busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        check("held start accepted", 32'(busy), 32'd1);
        finish_op(1'b1, 4'd15, 4'd0, 1'b0, 4'd3, 4'd1, 1'b0, "held start second");

        // Reset pulse in the second CALC cycle of 7/2
        @(negedge clk);
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort quotient", 32'(quotient), 32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        check("abort div_by_zero", 32'(div_by_zero), 32'd0);
        dividend = 4'd10;
        divisor  = 4'd3;
        start    = 1'b1;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Any done from the aborted 7/2 would show up before latency W here.
        finish_op(1'b1, 4'd3, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, "after abort 10/3");

        // Random operations
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            ref_div(int'(ra), int'(rb), mq, mr, mz);
            do_div(ra, rb, mq, mr, mz, $sformatf("rand %0d/%0d", ra, rb));
        end

        // Exhaustive sweep, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                ref_div(a, b, mq, mr, mz);
                do_div(W'(a), W'(b), mq, mr, mz, $sformatf("sweep %0d/%0d", a, b));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divider_4b.md
DIVIDER_4B -- requirements
Module: divider_4b

Interface
REQ-001 SHALL provide parameter W, default 4, giving the operand/result width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, W, unsigned numerator; sampled with start.
REQ-006 SHALL have port divisor, input, W, unsigned denominator; sampled with start.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress (CALC state).
REQ-008 SHALL have port done, output, 1, one-cycle pulse when results become valid.
REQ-009 SHALL have port quotient, output, W, registered quotient.
REQ-010 SHALL have port remainder, output, W, registered remainder.
REQ-011 SHALL have port div_by_zero, output, 1, registered flag, valid alongside quotient.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE, using unsigned restoring division (inverse of the team's ripple add: repeated trial subtraction).
REQ-013 IDLE: on start=1 at a clock edge, SHALL latch dividend and divisor internally, clear the partial remainder, load bit counter = W-1 and go to CALC, except as in REQ-017.
REQ-014 CALC: each cycle SHALL shift the partial remainder left by one, inserting the current dividend MSB; form trial = remainder - divisor in W+1 bits; if trial is non-negative, remainder = trial and quotient bit = 1, else remainder is unchanged and quotient bit = 0.
REQ-015 CALC SHALL last exactly W cycles (counter W-1 down to 0); the edge that processes counter 0 SHALL load quotient, remainder and div_by_zero=0 and go to DONE.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 divisor=0 sampled with start SHALL bypass CALC and go directly to DONE, with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-018 Latency: for start sampled at edge N, done SHALL be high from edge N+W+1 to N+W+2 (N+1 to N+2 for divide-by-zero).
REQ-019 busy SHALL be 1 exactly in CALC; done SHALL be 1 exactly in DONE; busy and done SHALL never be high together.
REQ-020 start in CALC or DONE SHALL be ignored, with no effect on the operation in flight. A new start SHALL only be accepted once back in IDLE (earliest: the edge after done).
REQ-021 quotient, remainder and div_by_zero SHALL hold their last values until the next completion overwrites them; internal partial results SHALL NOT be visible on these ports during CALC.
REQ-022 Operand changes after the start edge SHALL NOT affect the result.
REQ-023 For divisor != 0, results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear the internal counter and operand registers.
REQ-025 Reset asserted mid-CALC SHALL abort the operation and produce no done pulse. After release, the first start SHALL be processed normally.
REQ-026 start sampled on the first edge after rst_n deasserts SHALL be accepted.

Verification
REQ-027 W=4: dividend=13, divisor=4, start at edge N -> busy high edges N+1..N+4; done at edge N+5 with quotient=3, remainder=1, div_by_zero=0.
REQ-028 dividend=15, divisor=1 -> quotient=15, remainder=0. dividend=3, divisor=7 -> quotient=0, remainder=3. dividend=0, divisor=5 -> quotient=0, remainder=0.
REQ-029 dividend=9, divisor=0 -> done at edge N+1 with no busy cycle, quotient=15, remainder=9, div_by_zero=1.
REQ-030 start 13/4, then start=1 with 15/1 held throughout CALC and DONE -> first result 3/1; 15/1 is accepted only at the edge after done; second result 15/0.
REQ-031 rst_n pulsed low asynchronously during the 2nd CALC cycle -> all outputs 0 at once, no done pulse. A subsequent 10/3 -> quotient=3, remainder=1.
REQ-032 Exhaustive sweep of all 256 operand pairs back-to-back -> every result matches REQ-017/REQ-023, and each done comes exactly W+1 (or 1) cycles after its start edge.
